// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, services MF/MT ops
// and reports Busy so the stall unit can hold dependent instructions in D.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  XALUOp,
    input  logic [31:0] XALUa,
    input  logic [31:0] XALUb,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] XALU_Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic { IDLE, RUN } state_t;

    state_t      state, state_next;
    cnt_t        count, count_next;
    logic [31:0] hi_next, lo_next;
    logic [31:0] pend_hi, pend_lo, pend_hi_next, pend_lo_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        div_by_zero;
    logic        is_start_op;

    // Results are computed from the issue-cycle operands and parked until the countdown ends
    assign prod_s = {{32{XALUa[31]}}, XALUa} * {{32{XALUb[31]}}, XALUb};
    assign prod_u = {32'd0, XALUa} * {32'd0, XALUb};

    assign a_mag  = XALUa[31] ? (~XALUa + 32'd1) : XALUa;
    assign b_mag  = XALUb[31] ? (~XALUb + 32'd1) : XALUb;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000 keeps its bit pattern
    assign quot_s = (XALUa[31] ^ XALUb[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = XALUa[31] ? (~r_mag + 32'd1) : r_mag;
    assign quot_u = XALUa / XALUb;
    assign rem_u  = XALUa % XALUb;
    assign div_by_zero = (XALUb == 32'd0);

    assign is_start_op = (XALUOp == OP_MULT) || (XALUOp == OP_MULTU) ||
                         (XALUOp == OP_DIV)  || (XALUOp == OP_DIVU);
    assign Busy  = (state == RUN);
    assign Start = is_start_op && !Busy;

    always_comb begin
        XALU_Out = 32'd0;
        if (XALUOp == OP_MFHI)
            XALU_Out = HI;
        else if (XALUOp == OP_MFLO)
            XALU_Out = LO;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            HI      <= hi_next;
            LO      <= lo_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        hi_next      = HI;
        lo_next      = LO;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                    case (XALUOp)
                        OP_MULT: begin
                            {pend_hi_next, pend_lo_next} = prod_s;
                            count_next = cnt_t'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {pend_hi_next, pend_lo_next} = prod_u;
                            count_next = cnt_t'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            pend_hi_next = div_by_zero ? XALUa : rem_s;
                            pend_lo_next = div_by_zero ? 32'hFFFF_FFFF : quot_s;
                            count_next   = cnt_t'(DIV_CYCLES);
                        end
                        default: begin
                            pend_hi_next = div_by_zero ? XALUa : rem_u;
                            pend_lo_next = div_by_zero ? 32'hFFFF_FFFF : quot_u;
                            count_next   = cnt_t'(DIV_CYCLES);
                        end
                    endcase
                end else if (XALUOp == OP_MTHI) begin
                    hi_next = XALUa;
                end else if (XALUOp == OP_MTLO) begin
                    lo_next = XALUa;
                end
            end
            RUN: begin
                count_next = count - cnt_t'(1);
                if (count == cnt_t'(1)) begin
                    hi_next    = pend_hi;
                    lo_next    = pend_lo;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model of HI/LO and Busy duration.
module tb_muldiv_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  XALUOp;
    logic [31:0] XALUa, XALUb;
    logic        Start, Busy;
    logic [31:0] XALU_Out, HI, LO;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .XALUOp   (XALUOp),
        .XALUa    (XALUa),
        .XALUb    (XALUb),
        .Start    (Start),
        .Busy     (Busy),
        .XALU_Out (XALU_Out),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        XALUOp = op;
        XALUa  = a;
        XALUb  = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI,LO} straight from the architectural arithmetic rules
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic doOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        logic [63:0] r;
        applyStimulus(op, a, b);
        if (op >= 4'd1 && op <= 4'd4) begin
            checkOutput("start", {31'd0, Start}, 32'd1);
            checkOutput("busy_pre", {31'd0, Busy}, 32'd0);
            r = refResult(op, a, b);
            step();
            applyStimulus(4'd0, 32'd0, 32'd0);
            cycles = 0;
            while (Busy && cycles < 200) begin
                cycles++;
                step();
            end
            checkOutput("busy_len", 32'(cycles), (op <= 4'd2) ? 32'(MULT_N) : 32'(DIV_N));
            {exp_hi, exp_lo} = r;
            checkOutput("hi", HI, exp_hi);
            checkOutput("lo", LO, exp_lo);
        end else if (op == 4'd5 || op == 4'd6) begin
            checkOutput("start_mf", {31'd0, Start}, 32'd0);
            checkOutput("mf_out", XALU_Out, (op == 4'd5) ? exp_hi : exp_lo);
            step();
        end else begin
            checkOutput("start_other", {31'd0, Start}, 32'd0);
            checkOutput("out_zero", XALU_Out, 32'd0);
            step();
            if (op == 4'd7) exp_hi = a;
            if (op == 4'd8) exp_lo = a;
            checkOutput("hi_mt", HI, exp_hi);
            checkOutput("lo_mt", LO, exp_lo);
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b0;
        applyStimulus(4'd0, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b1;
        checkOutput("rst_hi", HI, 32'd0);
        checkOutput("rst_lo", LO, 32'd0);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);

        doOp(4'd1, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult_hi_const", HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", LO, 32'hFFFF_FFEB);
        doOp(4'd5, 32'd0, 32'd0);
        doOp(4'd6, 32'd0, 32'd0);
        doOp(4'd2, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu_hi_const", HI, 32'd1);
        checkOutput("multu_lo_const", LO, 32'hFFFF_FFFE);
        doOp(4'd3, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_lo_const", LO, 32'hFFFF_FFFD);
        checkOutput("div_hi_const", HI, 32'hFFFF_FFFF);
        doOp(4'd4, 32'd7, 32'd0);
        checkOutput("divu0_lo_const", LO, 32'hFFFF_FFFF);
        checkOutput("divu0_hi_const", HI, 32'd7);
        doOp(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf_lo_const", LO, 32'h8000_0000);
        checkOutput("divovf_hi_const", HI, 32'd0);

        // Ops presented while busy must be ignored
        applyStimulus(4'd1, 32'd1234, 32'd5678);
        checkOutput("ign_start0", {31'd0, Start}, 32'd1);
        step();
        applyStimulus(4'd8, 32'd5, 32'd0);
        checkOutput("ign_mtlo_start", {31'd0, Start}, 32'd0);
        step();
        applyStimulus(4'd1, 32'd99, 32'd99);
        checkOutput("ign_mult_start", {31'd0, Start}, 32'd0);
        step();
        applyStimulus(4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 20 && Busy; i++) step();
        checkOutput("ign_busy_done", {31'd0, Busy}, 32'd0);
        checkOutput("ign_hi", HI, 32'd0);
        checkOutput("ign_lo", LO, 32'd1234 * 32'd5678);
        exp_hi = 32'd0;
        exp_lo = 32'd1234 * 32'd5678;
        doOp(4'd8, 32'd5, 32'd0);
        doOp(4'd6, 32'd0, 32'd0);
        doOp(4'd5, 32'd0, 32'd0);

        // Reset in the fourth busy cycle of a divide cancels it
        doOp(4'd7, 32'hDEAD_BEEF, 32'd0);
        applyStimulus(4'd3, 32'd100, 32'd7);
        step();
        applyStimulus(4'd0, 32'd0, 32'd0);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkOutput("mid_rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("mid_rst_hi", HI, 32'd0);
        checkOutput("mid_rst_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) step();
        checkOutput("no_late_hi", HI, 32'd0);
        checkOutput("no_late_lo", LO, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // Back-to-back: DIV presented the cycle Busy first drops
        doOp(4'd1, 32'h0001_0000, 32'h0003_0000);
        doOp(4'd3, 32'hFFFF_FF00, 32'd9);

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 12));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            doOp(rop, ra, rb);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multiply/divide responder for the E stage of the 5-stage pipeline.
- Accepts XALU operations issued by the E stage, runs multi-cycle MULT/MULTU/DIV/DIVU, and holds the results in HI/LO.
- Services MFHI/MFLO/MTHI/MTLO.
- Reports Busy back to the stall unit so the initiator holds dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- XALUOp  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as none.
- XALUa  input  32  forwarded rs value.
- XALUb  input  32  forwarded rt value.
- Start  output  1  combinational; 1 when XALUOp is 1-4 and Busy==0 (start accepted this cycle).
- Busy  output  1  registered; 1 while an operation is in flight.
- XALU_Out  output  32  combinational read: HI for op 5, LO for op 6, 0 otherwise.
- HI  output  32  current HI register (debug/observe).
- LO  output  32  current LO register (debug/observe).

Behaviour:
- Reset (reset==0 at a rising edge):
  - HI=0, LO=0, Busy=0, internal counter=0, pending result discarded.
  - Reset mid-operation cancels the operation; HI/LO never receive its result.
- States: IDLE, RUN.
- IDLE:
  - On an edge with Start==1: latch the operands and op, load counter = MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4), Busy<=1, go to RUN.
  - Result is computed at accept time into pending registers; a counter-only implementation is permitted.
- RUN:
  - Each edge decrements the counter.
  - On the edge where the counter goes 1->0: HI/LO <= pending result, Busy<=0, return to IDLE.
  - Busy is therefore high for exactly N cycles after the accept edge; results are visible the cycle Busy first reads 0.
- Ops arriving while Busy==1: ops 1-4 and 7-8 are ignored (no state change, Start=0). The stall unit guarantees none arrive; the bench checks they are ignored anyway.
- MFHI/MFLO while Busy: XALU_Out returns the old register value (no error flag). The stall unit holds these instructions until Busy==0.
- MTHI/MTLO (Busy==0): HI or LO <= XALUa on the edge; visible on XALU_Out the next cycle. The other register is unchanged.
- Back-to-back issue: a new op 1-4 presented in the cycle Busy first reads 0 is accepted.
- Arithmetic:
  - MULT: {HI,LO} = signed64(XALUa) * signed64(XALUb).
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): LO=32'hFFFFFFFF, HI=XALUa, for both DIV and DIVU.
  - Signed overflow (a=32'h80000000, b=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Busy does not depend combinationally on XALUOp. Start does, and the stall unit uses (Start | Busy).

Test Plan:
- Reset, then MULT a=32'hFFFFFFFD (-3), b=7 -> Start=1 in the issue cycle; Busy=1 for 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; MFHI/MFLO return the same values.
- MULTU a=32'hFFFFFFFF, b=2 -> after 5 cycles HI=1, LO=32'hFFFFFFFE.
- DIV a=-7, b=2 -> after 10 Busy cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU a=7, b=0 -> LO=32'hFFFFFFFF, HI=7. DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
- Issue MULT, then hold MTLO a=5 and MULT on XALUOp during Busy -> both ignored (Start=0); final HI/LO equal the first MULT result. Then MTLO 5 -> LO=5 next cycle, HI unchanged.
- Start DIV, assert reset=0 for one edge at Busy cycle 4 -> Busy=0, HI=LO=0 next cycle; no late write after the original completion time.
- MULT immediately followed by DIV presented in the cycle Busy first reads 0 -> DIV accepted that cycle; Busy has a zero-gap low exactly one cycle wide; final result is the DIV result.
